// File: rtl/eth_cfg_pkg.sv
// Shared types and the Eth0 MAC init table for the configuration sequencer.
package eth_cfg_pkg;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    ISSUE = 3'd1,
    GAP   = 3'd2,
    WAIT  = 3'd3,
    RUN   = 3'd4
  } state_t;

  typedef enum logic {
    INIT = 1'b0,
    HOST = 1'b1
  } src_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } cfg_entry_t;

  localparam int INIT_TABLE_LEN = 8;
  localparam int TAB_AW         = $clog2(INIT_TABLE_LEN);

  // Writes replayed into the MAC after every reset, in this order.
  localparam cfg_entry_t ETH0_INIT_TABLE [INIT_TABLE_LEN] = '{
    '{addr: 8'h00, data: 32'h0000_8000},
    '{addr: 8'h04, data: 32'h0000_0003},
    '{addr: 8'h08, data: 32'h1122_3344},
    '{addr: 8'h0C, data: 32'h0000_5566},
    '{addr: 8'h14, data: 32'h0000_05EE},
    '{addr: 8'h18, data: 32'h0000_000C},
    '{addr: 8'h1C, data: 32'hFFFF_0000},
    '{addr: 8'h24, data: 32'h0000_0001}
  };

endpackage

// File: rtl/eth_cfg_rom.sv
// Synchronous one-cycle-latency lookup into the Eth0 init table.
module eth_cfg_rom
  import eth_cfg_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk_hifreq,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx,
  output cfg_entry_t       entry
);

  logic [TAB_AW-1:0] tab_sel_s;
  cfg_entry_t        entry_r;

  assign tab_sel_s = TAB_AW'(idx);
  assign entry     = entry_r;

  // Register the table word addressed by idx; indices past the table read as zero.
  always_ff @(posedge clk_hifreq or negedge rst_n) begin
    if (!rst_n) begin
      entry_r <= '0;
    end else if (int'(idx) < INIT_TABLE_LEN) begin
      entry_r <= ETH0_INIT_TABLE[tab_sel_s];
    end else begin
      entry_r <= '0;
    end
  end

endmodule

// File: rtl/eth_cfg_sequencer.sv
// Eth0 MAC register-write owner: replays the init table after reset, then
// serves host writes, bounding every write with a busy timeout.
module eth_cfg_sequencer
  import eth_cfg_pkg::*;
#(
  parameter int NUM_INIT   = 8,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk_hifreq,
  input  logic        rst_n,
  input  logic        busy,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [7:0]  host_addr,
  input  logic [31:0] host_data,
  output logic [7:0]  reg_addr,
  output logic [31:0] data_out,
  output logic        wren,
  output logic        init_done,
  output logic        cfg_err,
  output logic [7:0]  timeout_addr
);

  localparam int IDX_W = $clog2(NUM_INIT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INIT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  state_t            state_r, state_nxt_s;
  src_t              src_r, src_nxt_s;
  logic [IDX_W-1:0]  idx_r, idx_nxt_s;
  logic [GAP_W-1:0]  gap_cnt_r, gap_cnt_nxt_s;
  logic [TO_W-1:0]   to_cnt_r, to_cnt_nxt_s;
  logic              wren_r, wren_nxt_s;
  logic [7:0]        reg_addr_r, reg_addr_nxt_s;
  logic [31:0]       data_out_r, data_out_nxt_s;
  logic              init_done_r, init_done_nxt_s;
  logic              cfg_err_r, cfg_err_nxt_s;
  logic [7:0]        timeout_addr_r, timeout_addr_nxt_s;
  logic              host_ready_s;
  logic              wr_done_s;
  cfg_entry_t        rom_entry_s;

  eth_cfg_rom #(
    .IDX_W(IDX_W)
  ) u_rom (
    .clk_hifreq(clk_hifreq),
    .rst_n     (rst_n),
    .idx       (idx_r),
    .entry     (rom_entry_s)
  );

  assign host_ready   = host_ready_s;
  assign reg_addr     = reg_addr_r;
  assign data_out     = data_out_r;
  assign wren         = wren_r;
  assign init_done    = init_done_r;
  assign cfg_err      = cfg_err_r;
  assign timeout_addr = timeout_addr_r;

  // Next-state and next-output computation; wren defaults low so every strobe is one cycle.
  always_comb begin
    state_nxt_s        = state_r;
    src_nxt_s          = src_r;
    idx_nxt_s          = idx_r;
    gap_cnt_nxt_s      = gap_cnt_r;
    to_cnt_nxt_s       = to_cnt_r;
    wren_nxt_s         = 1'b0;
    reg_addr_nxt_s     = reg_addr_r;
    data_out_nxt_s     = data_out_r;
    init_done_nxt_s    = init_done_r;
    cfg_err_nxt_s      = cfg_err_r;
    timeout_addr_nxt_s = timeout_addr_r;
    host_ready_s       = 1'b0;
    wr_done_s          = 1'b0;

    case (state_r)
      FETCH: begin
        state_nxt_s = ISSUE;
      end
      ISSUE: begin
        if (!busy) begin
          wren_nxt_s     = 1'b1;
          reg_addr_nxt_s = rom_entry_s.addr;
          data_out_nxt_s = rom_entry_s.data;
          gap_cnt_nxt_s  = '0;
          src_nxt_s      = INIT;
          state_nxt_s    = GAP;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      GAP: begin
        // busy is not trusted here: the MAC may not have raised it yet.
        if (gap_cnt_r == GAP_LAST) begin
          to_cnt_nxt_s = '0;
          state_nxt_s  = WAIT;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r + GAP_W'(1);
        end
      end
      WAIT: begin
        if (!busy) begin
          wr_done_s = 1'b1;
        end else if (to_cnt_r == TO_LAST) begin
          // Abandon the write but remember where it went.
          wr_done_s          = 1'b1;
          cfg_err_nxt_s      = 1'b1;
          timeout_addr_nxt_s = reg_addr_r;
        end else begin
          to_cnt_nxt_s = to_cnt_r + TO_W'(1);
        end

        if (wr_done_s) begin
          if (src_r == HOST) begin
            state_nxt_s = RUN;
          end else if (idx_r == LAST_IDX) begin
            init_done_nxt_s = 1'b1;
            state_nxt_s     = RUN;
          end else begin
            idx_nxt_s   = idx_r + IDX_W'(1);
            state_nxt_s = FETCH;
          end
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RUN: begin
        host_ready_s = !busy;
        if (host_valid && !busy) begin
          wren_nxt_s     = 1'b1;
          reg_addr_nxt_s = host_addr;
          data_out_nxt_s = host_data;
          gap_cnt_nxt_s  = '0;
          src_nxt_s      = HOST;
          state_nxt_s    = GAP;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = FETCH;
      end
    endcase
  end

  // State and registered-output update; reset drops wren immediately and restarts the replay.
  always_ff @(posedge clk_hifreq or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= FETCH;
      src_r          <= INIT;
      idx_r          <= '0;
      gap_cnt_r      <= '0;
      to_cnt_r       <= '0;
      wren_r         <= 1'b0;
      reg_addr_r     <= 8'h00;
      data_out_r     <= 32'h0000_0000;
      init_done_r    <= 1'b0;
      cfg_err_r      <= 1'b0;
      timeout_addr_r <= 8'h00;
    end else begin
      state_r        <= state_nxt_s;
      src_r          <= src_nxt_s;
      idx_r          <= idx_nxt_s;
      gap_cnt_r      <= gap_cnt_nxt_s;
      to_cnt_r       <= to_cnt_nxt_s;
      wren_r         <= wren_nxt_s;
      reg_addr_r     <= reg_addr_nxt_s;
      data_out_r     <= data_out_nxt_s;
      init_done_r    <= init_done_nxt_s;
      cfg_err_r      <= cfg_err_nxt_s;
      timeout_addr_r <= timeout_addr_nxt_s;
    end
  end

endmodule

// File: tb/tb_eth_cfg_sequencer.sv
// Scoreboard bench for eth_cfg_sequencer with a simple MAC busy model.
module tb_eth_cfg_sequencer;
  import eth_cfg_pkg::*;

  localparam int NUM_INIT   = 8;
  localparam int GAP_CYCLES = 2;
  localparam int TIMEOUT    = 16;

  logic        clk_hifreq = 1'b0;
  logic        rst_n      = 1'b0;
  logic        busy;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [7:0]  host_addr  = 8'h00;
  logic [31:0] host_data  = 32'h0;
  logic [7:0]  reg_addr;
  logic [31:0] data_out;
  logic        wren;
  logic        init_done;
  logic        cfg_err;
  logic [7:0]  timeout_addr;

  logic mac_busy   = 1'b0;
  logic mac_en     = 1'b1;
  logic force_busy = 1'b0;
  logic stuck      = 1'b0;
  logic stuck_arm  = 1'b0;
  logic prev_wren  = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_wr     = 0;
  int mac_cnt  = 0;

  cfg_entry_t sb[$];
  int         wtimes[$];

  assign busy = stuck | force_busy | (mac_en & mac_busy);

  eth_cfg_sequencer #(
    .NUM_INIT  (NUM_INIT),
    .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_hifreq  (clk_hifreq),
    .rst_n       (rst_n),
    .busy        (busy),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .reg_addr    (reg_addr),
    .data_out    (data_out),
    .wren        (wren),
    .init_done   (init_done),
    .cfg_err     (cfg_err),
    .timeout_addr(timeout_addr)
  );

  initial forever #5 clk_hifreq = ~clk_hifreq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Main-thread sampling point, well clear of both clock edges.
  task automatic tick();
    @(posedge clk_hifreq);
    #3;
  endtask

  task automatic release_reset();
    sb.delete();
    for (int i = 0; i < NUM_INIT; i++) sb.push_back(ETH0_INIT_TABLE[i]);
    rst_n = 1'b1;
  endtask

  // Monitor + MAC model: score every wren pulse; busy rises 1 cycle after wren for 3 cycles.
  initial forever begin
    @(negedge clk_hifreq);
    cyc++;
    if (!rst_n) begin
      n_wr      = 0;
      mac_cnt   = 0;
      mac_busy  = 1'b0;
      prev_wren = 1'b0;
    end else begin
      if (!init_done) chk("ready_lock", host_ready, 64'd0);
      if (wren) begin
        cfg_entry_t e;
        chk("wren_width", prev_wren, 64'd0);
        chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("wr_addr", reg_addr, e.addr);
          chk("wr_data", data_out, e.data);
        end
        n_wr++;
        wtimes.push_back(cyc);
        if (stuck_arm && n_wr == 4) stuck = 1'b1;
        mac_cnt = 3;
      end else if (mac_cnt > 0) begin
        mac_cnt--;
      end
      mac_busy  = (mac_cnt > 0);
      prev_wren = wren;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog n_wr=%0d", n_wr);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    cfg_entry_t h;

    // Host request pending from cycle 0, through reset and init.
    host_valid = 1'b1;
    host_addr  = 8'h20;
    host_data  = 32'hDEAD_BEEF;
    repeat (3) tick();
    chk("rst_wren", wren, 64'd0);
    chk("rst_done", init_done, 64'd0);
    chk("rst_err", cfg_err, 64'd0);
    chk("rst_ready", host_ready, 64'd0);
    chk("rst_addr", reg_addr, 64'd0);
    chk("rst_data", data_out, 64'd0);
    chk("rst_toaddr", timeout_addr, 64'd0);
    release_reset();

    // Phase 1: clean init replay, then the pending host write.
    k = 0;
    while (!host_ready && k < 400) begin tick(); k++; end
    chk("host_hs_seen", host_ready, 64'd1);
    if (host_ready) begin
      chk("hs_after_init", init_done, 64'd1);
      chk("sb_init_drained", sb.size(), 64'd0);
      h.addr = host_addr; h.data = host_data;
      sb.push_back(h);
      @(posedge clk_hifreq); #1;
      host_valid = 1'b0;
    end
    repeat (12) tick();
    chk("p1_sb_empty", sb.size(), 64'd0);
    chk("p1_done", init_done, 64'd1);
    chk("p1_err", cfg_err, 64'd0);
    chk("p1_addr_hold", reg_addr, 64'h20);
    chk("p1_data_hold", data_out, 64'hDEAD_BEEF);

    // Phase 2: reset clears init_done, then busy sticks after entry 3.
    rst_n = 1'b0;
    #1;
    chk("rst2_done", init_done, 64'd0);
    chk("rst2_addr", reg_addr, 64'd0);
    repeat (3) tick();
    stuck_arm = 1'b1;
    release_reset();
    k = 0;
    while (!stuck && k < 300) begin tick(); k++; end
    chk("stuck_reached", stuck, 64'd1);
    k = 0;
    while (!cfg_err && k < 60) begin tick(); k++; end
    chk("timeout_cycles", k, 64'd17);
    chk("timeout_err", cfg_err, 64'd1);
    chk("timeout_addr", timeout_addr, ETH0_INIT_TABLE[3].addr);
    stuck     = 1'b0;
    stuck_arm = 1'b0;

    // Reset while entry 5's strobe is high.
    k = 0;
    while (!(wren && n_wr == 5) && k < 200) begin tick(); k++; end
    chk("entry5_wren", wren, 64'd1);
    chk("err_sticky", cfg_err, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_wren", wren, 64'd0);
    chk("midrst_err", cfg_err, 64'd0);
    chk("midrst_done", init_done, 64'd0);
    chk("midrst_toaddr", timeout_addr, 64'd0);
    repeat (3) tick();
    release_reset();

    // Phase 3: full replay from entry 0.
    k = 0;
    while (!init_done && k < 300) begin tick(); k++; end
    chk("p3_done", init_done, 64'd1);
    repeat (6) tick();
    chk("p3_sb_empty", sb.size(), 64'd0);
    chk("p3_err", cfg_err, 64'd0);

    // busy held in RUN locks the host out; dropping it hands-shakes at once.
    force_busy = 1'b1;
    host_addr  = 8'h31;
    host_data  = 32'h1234_5678;
    host_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("busy_ready", host_ready, 64'd0);
      chk("busy_wren", wren, 64'd0);
    end
    force_busy = 1'b0;
    #1;
    chk("ready_on_drop", host_ready, 64'd1);
    h.addr = host_addr; h.data = host_data;
    sb.push_back(h);
    @(posedge clk_hifreq); #1;
    host_valid = 1'b0;
    #2;
    chk("wren_after_hs", wren, 64'd1);
    repeat (10) tick();

    // Back-to-back host writes with busy never asserted.
    mac_en = 1'b0;
    wtimes.delete();
    host_addr  = 8'h40;
    host_data  = 32'hA5A5_0001;
    host_valid = 1'b1;
    for (int item = 0; item < 2; item++) begin
      k = 0;
      while (!host_ready && k < 20) begin tick(); k++; end
      chk("b2b_ready", host_ready, 64'd1);
      h.addr = host_addr; h.data = host_data;
      sb.push_back(h);
      @(posedge clk_hifreq); #1;
      if (item == 0) begin
        host_addr = 8'h41;
        host_data = 32'h5A5A_0002;
      end else begin
        host_valid = 1'b0;
      end
      #2;
    end
    repeat (10) tick();
    chk("b2b_count", wtimes.size(), 64'd2);
    if (wtimes.size() == 2) chk("b2b_spacing", wtimes[1] - wtimes[0], GAP_CYCLES + 2);
    chk("b2b_sb_empty", sb.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
